data_access_sched: RTL and testbench

- Per-bank scheduler in front of the cache data store access block.
- Arbitrates between memory fill responses and core read/write requests, then drives the single-ported data access interface.
- Captures the 1-cycle-latency read data into a small response queue with credit-based flow control.
- After reset, sweeps every line with a zero fill before accepting traffic.

---
 rtl/data_access_sched_pkg.sv | 17 +
 rtl/data_access_sched_if.sv | 37 +++
 rtl/data_access_rsp_queue.sv | 71 +++++++
 rtl/data_access_sched.sv | 163 ++++++++++++++++
 tb/tb_data_access_sched.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_access_sched_pkg.sv
// Shared types and width helpers for the per-bank data access scheduler.
package data_access_sched_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } sched_state_e;

  function automatic int calc_wsel_w(input int words_per_line);
    return (words_per_line > 1) ? $clog2(words_per_line) : 1;
  endfunction

  function automatic int calc_lsel_w(input int lines);
    return (lines > 1) ? $clog2(lines) : 1;
  endfunction

endpackage

// File: rtl/data_access_sched_if.sv
// Single-ported data store access bus: the scheduler is master, the data store is slave.
interface data_access_sched_if #(
  parameter int NUM_PORTS      = 1,
  parameter int WORD_SIZE      = 4,
  parameter int WORDS_PER_LINE = 4,
  parameter int LINE_ADDR_W    = 26
);
  import data_access_sched_pkg::*;

  localparam int WORD_WIDTH = 8 * WORD_SIZE;
  localparam int WSEL_W     = calc_wsel_w(WORDS_PER_LINE);

  logic                                 da_stall;
  logic                                 da_read;
  logic                                 da_fill;
  logic                                 da_write;
  logic [LINE_ADDR_W-1:0]               da_addr;
  logic [NUM_PORTS*WSEL_W-1:0]          da_wsel;
  logic [NUM_PORTS-1:0]                 da_pmask;
  logic [NUM_PORTS*WORD_SIZE-1:0]       da_byteen;
  logic [WORDS_PER_LINE*WORD_WIDTH-1:0] da_fill_data;
  logic [NUM_PORTS*WORD_WIDTH-1:0]      da_write_data;
  logic [NUM_PORTS*WORD_WIDTH-1:0]      da_read_data;

  modport master (
    output da_stall, da_read, da_fill, da_write, da_addr, da_wsel, da_pmask,
           da_byteen, da_fill_data, da_write_data,
    input  da_read_data
  );

  modport slave (
    input  da_stall, da_read, da_fill, da_write, da_addr, da_wsel, da_pmask,
           da_byteen, da_fill_data, da_write_data,
    output da_read_data
  );

endinterface

// File: rtl/data_access_rsp_queue.sv
// Small FIFO holding read responses (data + tag) until the consumer takes them.
module data_access_rsp_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 40,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pop_ok   = pop && (count_q != '0);
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_ok) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign empty     = (count_q == '0);
  assign count     = count_q;

endmodule

// File: rtl/data_access_sched.sv
// Per-bank scheduler: zero-fills every line after reset, then arbitrates fills vs core
// requests onto the single-ported data store and queues read responses under credit control.
module data_access_sched
  import data_access_sched_pkg::*;
#(
  parameter int NUM_PORTS      = 1,
  parameter int WORD_SIZE      = 4,
  parameter int WORDS_PER_LINE = 4,
  parameter int LINES          = 64,
  parameter int LINE_ADDR_W    = 26,
  parameter int TAG_WIDTH      = 8,
  parameter int FILL_BURST     = 4,
  parameter int RSP_DEPTH      = 2
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          fill_valid,
  input  logic [LINE_ADDR_W-1:0]                        fill_addr,
  input  logic [WORDS_PER_LINE*8*WORD_SIZE-1:0]         fill_data_in,
  output logic                                          fill_ready,
  input  logic                                          core_valid,
  input  logic                                          core_rw,
  input  logic [LINE_ADDR_W-1:0]                        core_addr,
  input  logic [NUM_PORTS*calc_wsel_w(WORDS_PER_LINE)-1:0] core_wsel,
  input  logic [NUM_PORTS-1:0]                          core_pmask,
  input  logic [NUM_PORTS*WORD_SIZE-1:0]                core_byteen,
  input  logic [NUM_PORTS*8*WORD_SIZE-1:0]              core_data,
  input  logic [TAG_WIDTH-1:0]                          core_tag,
  output logic                                          core_ready,
  data_access_sched_if.master                           da,
  output logic                                          rsp_valid,
  output logic [NUM_PORTS*8*WORD_SIZE-1:0]              rsp_data,
  output logic [TAG_WIDTH-1:0]                          rsp_tag,
  input  logic                                          rsp_ready,
  output logic                                          init_done
);

  localparam int WORD_WIDTH = 8 * WORD_SIZE;
  localparam int LSEL_W     = calc_lsel_w(LINES);
  localparam int DATA_W     = NUM_PORTS * WORD_WIDTH;
  localparam int CNT_W      = $clog2(RSP_DEPTH + 1);
  localparam int BURST_W    = $clog2(FILL_BURST + 1);

  sched_state_e        state_q, state_d;
  logic [LSEL_W-1:0]   init_cnt_q, init_cnt_d;
  logic [BURST_W-1:0]  burst_q, burst_d;
  logic                inflight_q, inflight_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;

  logic                core_elig;
  logic                grant_fill;
  logic                grant_core;
  logic                rsp_empty;
  logic [CNT_W-1:0]    rsp_count;

  data_access_rsp_queue #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_W + TAG_WIDTH),
    .CNT_W (CNT_W)
  ) u_rsp_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight_q),
    .push_data ({da.da_read_data, tag_q}),
    .pop       (rsp_valid && rsp_ready),
    .head_data ({rsp_data, rsp_tag}),
    .empty     (rsp_empty),
    .count     (rsp_count)
  );

  assign rsp_valid = !rsp_empty;
  assign init_done = (state_q == ST_RUN) && !reset;

  // Credit counts the queued responses plus the read whose data lands next cycle.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    burst_d    = burst_q;
    inflight_d = 1'b0;
    tag_d      = tag_q;

    fill_ready       = 1'b0;
    core_ready       = 1'b0;
    da.da_stall      = 1'b1;
    da.da_read       = 1'b0;
    da.da_fill       = 1'b0;
    da.da_write      = 1'b0;
    da.da_addr       = '0;
    da.da_wsel       = '0;
    da.da_pmask      = '0;
    da.da_byteen     = '0;
    da.da_fill_data  = '0;
    da.da_write_data = '0;

    core_elig  = core_valid &&
                 (core_rw || ((int'(rsp_count) + int'(inflight_q)) < RSP_DEPTH));
    grant_fill = 1'b0;
    grant_core = 1'b0;

    if (!reset) begin
      case (state_q)
        ST_INIT: begin
          da.da_fill  = 1'b1;
          da.da_stall = 1'b0;
          da.da_addr  = LINE_ADDR_W'(init_cnt_q);
          init_cnt_d  = init_cnt_q + LSEL_W'(1);
          if (init_cnt_q == LSEL_W'(LINES - 1)) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          grant_fill = fill_valid && !(core_elig && (burst_q == BURST_W'(FILL_BURST)));
          grant_core = !grant_fill && core_elig;

          if (grant_core || !core_elig) begin
            burst_d = '0;
          end else if (grant_fill && (burst_q != BURST_W'(FILL_BURST))) begin
            burst_d = burst_q + BURST_W'(1);
          end

          if (grant_fill) begin
            fill_ready      = 1'b1;
            da.da_fill      = 1'b1;
            da.da_stall     = 1'b0;
            da.da_addr      = fill_addr;
            da.da_fill_data = fill_data_in;
          end else if (grant_core) begin
            core_ready       = 1'b1;
            da.da_read       = !core_rw;
            da.da_write      = core_rw;
            da.da_stall      = 1'b0;
            da.da_addr       = core_addr;
            da.da_wsel       = core_wsel;
            da.da_pmask      = core_pmask;
            da.da_byteen     = core_byteen;
            da.da_write_data = core_data;
            inflight_d       = !core_rw;
            if (!core_rw) begin
              tag_d = core_tag;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      burst_q    <= '0;
      inflight_q <= 1'b0;
      tag_q      <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      burst_q    <= burst_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
    end
  end

endmodule

// File: tb/tb_data_access_sched.sv
// Directed bench for data_access_sched: init sweep, grant table, credit/latency sequences, mid-run reset.
module tb_data_access_sched;

  localparam int NUM_PORTS      = 1;
  localparam int WORD_SIZE      = 4;
  localparam int WORDS_PER_LINE = 4;
  localparam int LINES          = 64;
  localparam int LINE_ADDR_W    = 26;
  localparam int TAG_WIDTH      = 8;
  localparam int FILL_BURST     = 4;
  localparam int RSP_DEPTH      = 2;
  localparam int NV             = 34;

  localparam logic [127:0] FILL_PAT = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [31:0]  WR_DATA  = 32'hA5A5_5A5A;

  logic         clk = 1'b0;
  logic         reset;
  logic         fill_valid;
  logic [25:0]  fill_addr;
  logic [127:0] fill_data_in;
  logic         fill_ready;
  logic         core_valid;
  logic         core_rw;
  logic [25:0]  core_addr;
  logic [1:0]   core_wsel;
  logic [0:0]   core_pmask;
  logic [3:0]   core_byteen;
  logic [31:0]  core_data;
  logic [7:0]   core_tag;
  logic         core_ready;
  logic         rsp_valid;
  logic [31:0]  rsp_data;
  logic [7:0]   rsp_tag;
  logic         rsp_ready;
  logic         init_done;

  int num_checks = 0;
  int num_fails  = 0;

  data_access_sched_if #(
    .NUM_PORTS      (NUM_PORTS),
    .WORD_SIZE      (WORD_SIZE),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .LINE_ADDR_W    (LINE_ADDR_W)
  ) da_if ();

  data_access_sched #(
    .NUM_PORTS      (NUM_PORTS),
    .WORD_SIZE      (WORD_SIZE),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .LINES          (LINES),
    .LINE_ADDR_W    (LINE_ADDR_W),
    .TAG_WIDTH      (TAG_WIDTH),
    .FILL_BURST     (FILL_BURST),
    .RSP_DEPTH      (RSP_DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fill_valid   (fill_valid),
    .fill_addr    (fill_addr),
    .fill_data_in (fill_data_in),
    .fill_ready   (fill_ready),
    .core_valid   (core_valid),
    .core_rw      (core_rw),
    .core_addr    (core_addr),
    .core_wsel    (core_wsel),
    .core_pmask   (core_pmask),
    .core_byteen  (core_byteen),
    .core_data    (core_data),
    .core_tag     (core_tag),
    .core_ready   (core_ready),
    .da           (da_if),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_tag      (rsp_tag),
    .rsp_ready    (rsp_ready),
    .init_done    (init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fv;
    logic [25:0] faddr;
    logic        cv;
    logic        rw;
    logic [25:0] caddr;
    logic [7:0]  tag;
    logic [31:0] rdata;
    logic        rr;
    logic        e_fr;
    logic        e_cr;
    logic        e_rd;
    logic        e_wr;
    logic        e_fl;
    logic [25:0] e_addr;
    logic        e_rv;
    logic [7:0]  e_tag;
    logic [31:0] e_rdat;
  } vec_t;

  vec_t vecs [NV];

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic idleInputs();
    fill_valid   = 1'b0;
    fill_addr    = '0;
    fill_data_in = FILL_PAT;
    core_valid   = 1'b0;
    core_rw      = 1'b0;
    core_addr    = '0;
    core_wsel    = 2'b10;
    core_pmask   = 1'b1;
    core_byteen  = 4'b1011;
    core_data    = WR_DATA;
    core_tag     = '0;
    rsp_ready    = 1'b1;
    da_if.da_read_data = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    idleInputs();
    fill_valid         = v.fv;
    fill_addr          = v.faddr;
    core_valid         = v.cv;
    core_rw            = v.rw;
    core_addr          = v.caddr;
    core_tag           = v.tag;
    rsp_ready          = v.rr;
    da_if.da_read_data = v.rdata;
  endtask

  task automatic checkVector(input int i, input vec_t v);
    checkOutput($sformatf("v%0d fill_ready", i), fill_ready, v.e_fr);
    checkOutput($sformatf("v%0d core_ready", i), core_ready, v.e_cr);
    checkOutput($sformatf("v%0d da_read", i), da_if.da_read, v.e_rd);
    checkOutput($sformatf("v%0d da_write", i), da_if.da_write, v.e_wr);
    checkOutput($sformatf("v%0d da_fill", i), da_if.da_fill, v.e_fl);
    checkOutput($sformatf("v%0d da_stall", i), da_if.da_stall, !(v.e_rd || v.e_wr || v.e_fl));
    checkOutput($sformatf("v%0d da_addr", i), da_if.da_addr, v.e_addr);
    checkOutput($sformatf("v%0d rsp_valid", i), rsp_valid, v.e_rv);
    if (v.e_rv) begin
      checkOutput($sformatf("v%0d rsp_tag", i), rsp_tag, v.e_tag);
      checkOutput($sformatf("v%0d rsp_data", i), rsp_data, v.e_rdat);
    end
    if (v.e_fl) begin
      checkOutput($sformatf("v%0d da_fill_data", i), da_if.da_fill_data, FILL_PAT);
    end
    if (v.e_wr) begin
      checkOutput($sformatf("v%0d da_write_data", i), da_if.da_write_data, WR_DATA);
      checkOutput($sformatf("v%0d da_byteen", i), da_if.da_byteen, 4'b1011);
      checkOutput($sformatf("v%0d da_wsel", i), da_if.da_wsel, 2'b10);
      checkOutput($sformatf("v%0d da_pmask", i), da_if.da_pmask, 1'b1);
    end
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Grant table (rsp_ready high), then read latency, credit backpressure, back-to-back reads.
    //         fv faddr    cv rw caddr    tag    rdata          rr fr cr rd wr fl e_addr   rv tag    rdat
    vecs[0]  = '{0, 26'h0,  0, 0, 26'h0,  8'h00, 32'h0,         1, 0, 0, 0, 0, 0, 26'h0,  0, 8'h00, 32'h0};
    vecs[1]  = '{0, 26'h0,  1, 1, 26'h7,  8'h00, 32'h0,         1, 0, 1, 0, 1, 0, 26'h7,  0, 8'h00, 32'h0};
    vecs[2]  = '{0, 26'h0,  1, 0, 26'h9,  8'h11, 32'h0,         1, 0, 1, 1, 0, 0, 26'h9,  0, 8'h00, 32'h0};
    vecs[3]  = '{1, 26'h20, 0, 0, 26'h0,  8'h00, 32'h12345678,  1, 1, 0, 0, 0, 1, 26'h20, 0, 8'h00, 32'h0};
    vecs[4]  = '{0, 26'h0,  0, 0, 26'h0,  8'h00, 32'hDEADBEEF,  1, 0, 0, 0, 0, 0, 26'h0,  1, 8'h11, 32'h12345678};
    vecs[5]  = '{1, 26'h30, 1, 1, 26'h44, 8'h00, 32'h0,         1, 1, 0, 0, 0, 1, 26'h30, 0, 8'h00, 32'h0};
    vecs[6]  = vecs[5];
    vecs[7]  = vecs[5];
    vecs[8]  = vecs[5];
    vecs[9]  = '{1, 26'h30, 1, 1, 26'h44, 8'h00, 32'h0,         1, 0, 1, 0, 1, 0, 26'h44, 0, 8'h00, 32'h0};
    vecs[10] = vecs[5];
    vecs[11] = '{1, 26'h31, 0, 0, 26'h0,  8'h00, 32'h0,         1, 1, 0, 0, 0, 1, 26'h31, 0, 8'h00, 32'h0};
    vecs[12] = '{1, 26'h32, 1, 1, 26'h45, 8'h00, 32'h0,         1, 1, 0, 0, 0, 1, 26'h32, 0, 8'h00, 32'h0};
    vecs[13] = vecs[0];
    vecs[14] = '{0, 26'h0,  1, 0, 26'h5,  8'h3A, 32'h0,         1, 0, 1, 1, 0, 0, 26'h5,  0, 8'h00, 32'h0};
    vecs[15] = '{0, 26'h0,  0, 0, 26'h0,  8'h00, 32'hCAFEBABE,  1, 0, 0, 0, 0, 0, 26'h0,  0, 8'h00, 32'h0};
    vecs[16] = '{0, 26'h0,  0, 0, 26'h0,  8'h00, 32'h0,         1, 0, 0, 0, 0, 0, 26'h0,  1, 8'h3A, 32'hCAFEBABE};
    vecs[17] = vecs[0];
    vecs[18] = '{0, 26'h0,  1, 0, 26'h10, 8'h01, 32'h0,         0, 0, 1, 1, 0, 0, 26'h10, 0, 8'h00, 32'h0};
    vecs[19] = '{0, 26'h0,  1, 0, 26'h11, 8'h02, 32'h1111,      0, 0, 1, 1, 0, 0, 26'h11, 0, 8'h00, 32'h0};
    vecs[20] = '{0, 26'h0,  1, 0, 26'h12, 8'h03, 32'h2222,      0, 0, 0, 0, 0, 0, 26'h0,  1, 8'h01, 32'h1111};
    vecs[21] = '{0, 26'h0,  1, 0, 26'h12, 8'h03, 32'hBAD0,      1, 0, 0, 0, 0, 0, 26'h0,  1, 8'h01, 32'h1111};
    vecs[22] = '{0, 26'h0,  1, 0, 26'h12, 8'h03, 32'hBAD1,      1, 0, 1, 1, 0, 0, 26'h12, 1, 8'h02, 32'h2222};
    vecs[23] = '{0, 26'h0,  0, 0, 26'h0,  8'h00, 32'h3333,      1, 0, 0, 0, 0, 0, 26'h0,  0, 8'h00, 32'h0};
    vecs[24] = '{0, 26'h0,  0, 0, 26'h0,  8'h00, 32'h0,         1, 0, 0, 0, 0, 0, 26'h0,  1, 8'h03, 32'h3333};
    vecs[25] = vecs[0];
    vecs[26] = '{0, 26'h0,  1, 0, 26'h20, 8'h40, 32'hD0000000,  1, 0, 1, 1, 0, 0, 26'h20, 0, 8'h00, 32'h0};
    vecs[27] = '{0, 26'h0,  1, 0, 26'h21, 8'h41, 32'hD0000001,  1, 0, 1, 1, 0, 0, 26'h21, 0, 8'h00, 32'h0};
    vecs[28] = '{0, 26'h0,  1, 0, 26'h22, 8'h42, 32'hD0000002,  1, 0, 0, 0, 0, 0, 26'h0,  1, 8'h40, 32'hD0000001};
    vecs[29] = '{0, 26'h0,  1, 0, 26'h22, 8'h42, 32'hD0000003,  1, 0, 1, 1, 0, 0, 26'h22, 1, 8'h41, 32'hD0000002};
    vecs[30] = '{0, 26'h0,  1, 0, 26'h23, 8'h43, 32'hD0000004,  1, 0, 1, 1, 0, 0, 26'h23, 0, 8'h00, 32'h0};
    vecs[31] = '{0, 26'h0,  1, 0, 26'h24, 8'h44, 32'hD0000005,  1, 0, 0, 0, 0, 0, 26'h0,  1, 8'h42, 32'hD0000004};
    vecs[32] = '{0, 26'h0,  0, 0, 26'h0,  8'h00, 32'hD0000006,  1, 0, 0, 0, 0, 0, 26'h0,  1, 8'h43, 32'hD0000005};
    vecs[33] = vecs[0];

    idleInputs();
    fill_valid = 1'b1;
    core_valid = 1'b1;
    reset      = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset da_stall", da_if.da_stall, 1'b1);
    checkOutput("reset da_fill", da_if.da_fill, 1'b0);
    checkOutput("reset da_read", da_if.da_read, 1'b0);
    checkOutput("reset da_write", da_if.da_write, 1'b0);
    checkOutput("reset fill_ready", fill_ready, 1'b0);
    checkOutput("reset core_ready", core_ready, 1'b0);
    checkOutput("reset rsp_valid", rsp_valid, 1'b0);
    checkOutput("reset init_done", init_done, 1'b0);

    // Init sweep: one zero fill per line, requests held off throughout.
    for (int k = 0; k < LINES; k++) begin
      @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput($sformatf("init%0d da_fill", k), da_if.da_fill, 1'b1);
      checkOutput($sformatf("init%0d da_stall", k), da_if.da_stall, 1'b0);
      checkOutput($sformatf("init%0d da_addr", k), da_if.da_addr, 26'(k));
      checkOutput($sformatf("init%0d da_fill_data", k), da_if.da_fill_data, 128'h0);
      checkOutput($sformatf("init%0d core_ready", k), core_ready, 1'b0);
      checkOutput($sformatf("init%0d fill_ready", k), fill_ready, 1'b0);
      checkOutput($sformatf("init%0d init_done", k), init_done, 1'b0);
    end
    @(negedge clk);
    idleInputs();
    #1;
    checkOutput("post-init init_done", init_done, 1'b1);
    checkOutput("post-init da_stall", da_if.da_stall, 1'b1);
    checkOutput("post-init da_fill", da_if.da_fill, 1'b0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkVector(i, vecs[i]);
    end

    // Mid-operation reset: the in-flight read must vanish and the sweep restart at line 0.
    @(negedge clk);
    idleInputs();
    core_valid = 1'b1;
    core_addr  = 26'h3;
    core_tag   = 8'h77;
    #1;
    checkOutput("midrst grant core_ready", core_ready, 1'b1);
    checkOutput("midrst grant da_read", da_if.da_read, 1'b1);
    @(negedge clk);
    idleInputs();
    reset = 1'b1;
    da_if.da_read_data = 32'h5555_5555;
    #1;
    checkOutput("midrst in-reset da_stall", da_if.da_stall, 1'b1);
    checkOutput("midrst in-reset da_read", da_if.da_read, 1'b0);
    checkOutput("midrst in-reset init_done", init_done, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput($sformatf("midrst%0d rsp_valid", k), rsp_valid, 1'b0);
      checkOutput($sformatf("midrst%0d da_fill", k), da_if.da_fill, 1'b1);
      checkOutput($sformatf("midrst%0d da_addr", k), da_if.da_addr, 26'(k));
      checkOutput($sformatf("midrst%0d core_ready", k), core_ready, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
